// File: rtl/reg_packer.sv
// reg_packer: 8x8 shadow register bank published as one 64-bit word; REG_PACKER_AUTO_COMMIT_EN adds commit-on-full-mask.
// Latency: commit -> rd_valid_o/rd_data_o 1 cycle; write -> mask_o 1 cycle; one word per cycle peak.
// Backpressure: a commit blocked by !rd_ready_i is held as a single merged pending request.
module reg_packer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_addr_i,
    input  logic [7:0]  wr_data_i,
    input  logic        commit_i,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic [63:0] rd_data_o,
    output logic [7:0]  mask_o,
    output logic        pend_o
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [7:0][7:0] sh_q, sh_d;
    logic [7:0]      mask_q, mask_d, mask_n;
    logic [63:0]     data_q, data_d;
    logic            pend_q, pend_d;
    logic            commit_req;

    // Bank and mask as they will look including this cycle's write.
    always_comb begin
        sh_d   = sh_q;
        mask_n = mask_q;
        if (wr_en_i) begin
            sh_d[wr_addr_i]   = wr_data_i;
            mask_n[wr_addr_i] = 1'b1;
        end
    end

`ifdef REG_PACKER_AUTO_COMMIT_EN
    assign commit_req = commit_i | (&mask_n);
`else
    assign commit_req = commit_i;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_n;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    data_d  = sh_d;
                    mask_d  = 8'h00;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rd_ready_i) begin
                    pend_d = 1'b0;
                    if (pend_q || commit_req) begin
                        // Snapshot is taken at acceptance, so writes made while pending are included.
                        data_d = sh_d;
                        mask_d = 8'h00;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (commit_req) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            sh_q    <= '0;
            mask_q  <= 8'h00;
            data_q  <= 64'h0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
        end
    end

    assign rd_valid_o = (state_q == HOLD);
    assign rd_data_o  = data_q;
    assign mask_o     = mask_q;
    assign pend_o     = pend_q;

endmodule
